// File: rtl/lsu_cache_port.sv
// Load/store front end: turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned
// cache read/write sequences, read-modify-write for sub-word stores, with a hit watchdog.
module lsu_cache_port #(
    parameter int unsigned MAX_WAIT = 63
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] c_addr,
    output logic        c_read,
    output logic        c_write,
    output logic [7:0]  c_data_in [0:3],
    input  logic [7:0]  c_data_out [0:3],
    input  logic        c_hit
);

    localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    localparam logic WD_EN = (MAX_WAIT > 0);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] WR_WAIT = 3'd2;
    localparam logic [2:0] RESP    = 3'd3;
    localparam logic [2:0] ERR     = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [2:0]       state, state_n;
    logic [1:0]       off_q, off_n;
    logic             we_q, we_n;
    logic [2:0]       f3_q, f3_n;
    logic [15:0]      wdata_q, wdata_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      rdata_n, c_addr_n;
    logic [7:0]       c_data_in_n [0:3];
    logic             ready_n, done_n, err_n, c_read_n, c_write_n;

    logic             req_bad;
    logic             timeout;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_val;
    logic [7:0]       merged [0:3];

    // Request legality: illegal funct3 for the direction, or misaligned halfword/word
    always_comb begin
        req_bad = 1'b1;
        case (req_funct3)
            F3_B:    req_bad = 1'b0;
            F3_H:    req_bad = req_addr[0];
            F3_W:    req_bad = |req_addr[1:0];
            F3_BU:   req_bad = req_we;
            F3_HU:   req_bad = req_we | req_addr[0];
            default: req_bad = 1'b1;
        endcase
    end

    // Load extraction/extension and sub-word store merge on the returned cache word
    always_comb begin
        ld_byte = c_data_out[off_q];
        ld_half = off_q[1] ? {c_data_out[3], c_data_out[2]} : {c_data_out[1], c_data_out[0]};
        case (f3_q)
            F3_B:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_val = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_val = {24'h0, ld_byte};
            F3_HU:   ld_val = {16'h0, ld_half};
            default: ld_val = {c_data_out[3], c_data_out[2], c_data_out[1], c_data_out[0]};
        endcase
        for (int k = 0; k < 4; k++) begin
            merged[k] = c_data_out[k];
            if (f3_q[1:0] == 2'b00 && off_q == 2'(k))
                merged[k] = wdata_q[7:0];
            else if (f3_q[1:0] == 2'b01 && off_q[1] == k[1])
                merged[k] = k[0] ? wdata_q[15:8] : wdata_q[7:0];
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_n     = state;
        off_n       = off_q;
        we_n        = we_q;
        f3_n        = f3_q;
        wdata_n     = wdata_q;
        cnt_n       = cnt;
        rdata_n     = rdata;
        c_addr_n    = c_addr;
        c_data_in_n = c_data_in;
        timeout     = WD_EN && (cnt == WAIT_LAST);

        case (state)
            IDLE: begin
                if (req_valid) begin
                    off_n   = req_addr[1:0];
                    we_n    = req_we;
                    f3_n    = req_funct3;
                    wdata_n = req_wdata[15:0];
                    cnt_n   = '0;
                    if (req_bad) begin
                        state_n = ERR;
                    end else begin
                        c_addr_n = {req_addr[31:2], 2'b00};
                        if (req_we && req_funct3 == F3_W) begin
                            state_n = WR_WAIT;
                            for (int k = 0; k < 4; k++)
                                c_data_in_n[k] = req_wdata[8*k +: 8];
                        end else begin
                            state_n = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (c_hit) begin
                    if (we_q) begin
                        c_data_in_n = merged;
                        cnt_n       = '0;
                        state_n     = WR_WAIT;
                    end else begin
                        rdata_n = ld_val;
                        state_n = RESP;
                    end
                end else if (timeout) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (c_hit)
                    state_n = RESP;
                else if (timeout)
                    state_n = ERR;
                else
                    cnt_n = cnt + CNT_W'(1);
            end
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        ready_n   = (state_n == IDLE);
        c_read_n  = (state_n == RD_WAIT);
        c_write_n = (state_n == WR_WAIT);
        done_n    = (state_n == RESP) || (state_n == ERR);
        err_n     = (state_n == ERR);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            off_q     <= 2'b00;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            wdata_q   <= 16'h0;
            cnt       <= '0;
            rdata     <= 32'h0;
            c_addr    <= 32'h0;
            c_data_in <= '{default: 8'h00};
            ready     <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            c_read    <= 1'b0;
            c_write   <= 1'b0;
        end else begin
            state     <= state_n;
            off_q     <= off_n;
            we_q      <= we_n;
            f3_q      <= f3_n;
            wdata_q   <= wdata_n;
            cnt       <= cnt_n;
            rdata     <= rdata_n;
            c_addr    <= c_addr_n;
            c_data_in <= c_data_in_n;
            ready     <= ready_n;
            done      <= done_n;
            err       <= err_n;
            c_read    <= c_read_n;
            c_write   <= c_write_n;
        end
    end

endmodule

// File: tb/tb_lsu_cache_port.sv
// Directed bench for lsu_cache_port: small word cache model with programmable hit latency,
// plus a second instance with MAX_WAIT=8 for watchdog behaviour.
module tb_lsu_cache_port;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req_valid, req_we, wd_req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        ready, done, err, c_read, c_write, c_hit;
    logic [31:0] rdata, c_addr;
    logic [7:0]  c_data_in [0:3];
    logic [7:0]  c_data_out [0:3];

    logic        wd_ready, wd_done, wd_err, wd_c_read, wd_c_write, wd_hit;
    logic [31:0] wd_rdata, wd_c_addr;
    logic [7:0]  wd_c_data_in [0:3];

    logic [31:0] mem [0:15];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;
    int          hit_lat;
    int          miss_cnt;
    int          both_cnt;
    int          n_cmp;
    int          n_fail;

    always #5 clk = ~clk;

    lsu_cache_port dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata), .c_addr(c_addr),
        .c_read(c_read), .c_write(c_write), .c_data_in(c_data_in),
        .c_data_out(c_data_out), .c_hit(c_hit)
    );

    lsu_cache_port #(.MAX_WAIT(8)) dut_wd (
        .clk(clk), .rst_b(rst_b), .req_valid(wd_req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .ready(wd_ready), .done(wd_done), .err(wd_err), .rdata(wd_rdata), .c_addr(wd_c_addr),
        .c_read(wd_c_read), .c_write(wd_c_write), .c_data_in(wd_c_data_in),
        .c_data_out(c_data_out), .c_hit(wd_hit)
    );

    // Cache model: hits after hit_lat cycles of a held strobe
    assign c_hit = (c_read || c_write) && (miss_cnt >= hit_lat);

    always @(posedge clk) begin
        if (!(c_read || c_write) || c_hit) miss_cnt <= 0;
        else                               miss_cnt <= miss_cnt + 1;
        if (pre_we)
            mem[pre_idx] <= pre_val;
        else if (c_write && c_hit)
            mem[{c_addr[13:12], c_addr[3:2]}] <= {c_data_in[3], c_data_in[2], c_data_in[1], c_data_in[0]};
    end

    always_comb begin
        for (int k = 0; k < 4; k++)
            c_data_out[k] = mem[{c_addr[13:12], c_addr[3:2]}][8*k +: 8];
    end

    always @(negedge clk) begin
        if ((c_read && c_write) || (wd_c_read && wd_c_write)) both_cnt <= both_cnt + 1;
    end

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one request to the main instance; report latency (cycles after accept), err,
    // strobe cycle counts, address seen on the strobes and the word presented for writing.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic e,
                           output int nrd, output int nwr, output logic [31:0] ca,
                           output logic [31:0] wrw);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; e = 1'bx; nrd = 0; nwr = 0; ca = 32'hx; wrw = 32'hx;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (c_read) begin nrd++; ca = c_addr; end
            if (c_write) begin
                nwr++; ca = c_addr;
                wrw = {c_data_in[3], c_data_in[2], c_data_in[1], c_data_in[0]};
            end
            if (done) begin lat = n; e = err; break; end
        end
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ready, done, err, c_read, c_write} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 10000", {ready, done, err, c_read, c_write});
        end
        n_cmp++;
        if ({rdata, c_addr} !== 64'h0) begin
            n_fail++; $display("FAIL reset_data: rdata=%h c_addr=%h expected 0", rdata, c_addr);
        end
        n_cmp++;
        if ({c_data_in[3], c_data_in[2], c_data_in[1], c_data_in[0]} !== 32'h0) begin
            n_fail++; $display("FAIL reset_cdin: got nonzero c_data_in, expected 0");
        end
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ads [5] = '{32'h1001, 32'h1001, 32'h1002, 32'h1002, 32'h1000};
        logic [31:0] exp [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
        int lat, nrd, nwr; logic e; logic [31:0] ca, wrw;
        hit_lat = 0;
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, f3s[i], ads[i], 32'h0, lat, e, nrd, nwr, ca, wrw);
            n_cmp++;
            if (rdata !== exp[i]) begin
                n_fail++; $display("FAIL load%0d_data: got %h expected %h", i, rdata, exp[i]);
            end
            n_cmp++;
            if ({lat, e, nrd, nwr} !== {32'd2, 1'b0, 32'd1, 32'd0}) begin
                n_fail++; $display("FAIL load%0d_timing: lat=%0d err=%b rd=%0d wr=%0d expected 2/0/1/0", i, lat, e, nrd, nwr);
            end
            n_cmp++;
            if (ca !== 32'h1000) begin
                n_fail++; $display("FAIL load%0d_caddr: got %h expected 00001000", i, ca);
            end
        end
    endtask

    task automatic test_stores;
        int lat, nrd, nwr; logic e; logic [31:0] ca, wrw;
        run_req(1'b1, 3'b000, 32'h1003, 32'h12345677, lat, e, nrd, nwr, ca, wrw);
        n_cmp++;
        if ({lat, e, nrd, nwr} !== {32'd3, 1'b0, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL sb_timing: lat=%0d err=%b rd=%0d wr=%0d expected 3/0/1/1", lat, e, nrd, nwr);
        end
        n_cmp++;
        if (wrw !== 32'h7799AABB) begin
            n_fail++; $display("FAIL sb_word: got %h expected 7799aabb", wrw);
        end
        run_req(1'b0, 3'b010, 32'h1000, 32'h0, lat, e, nrd, nwr, ca, wrw);
        n_cmp++;
        if (rdata !== 32'h7799AABB) begin
            n_fail++; $display("FAIL sb_readback: got %h expected 7799aabb", rdata);
        end
        run_req(1'b1, 3'b001, 32'h1000, 32'h0000CAFE, lat, e, nrd, nwr, ca, wrw);
        n_cmp++;
        if ({lat, wrw} !== {32'd3, 32'h7799CAFE}) begin
            n_fail++; $display("FAIL sh_word: lat=%0d word=%h expected 3/7799cafe", lat, wrw);
        end
        run_req(1'b0, 3'b001, 32'h1002, 32'h0, lat, e, nrd, nwr, ca, wrw);
        n_cmp++;
        if (rdata !== 32'h00007799) begin
            n_fail++; $display("FAIL lh_positive: got %h expected 00007799", rdata);
        end
        run_req(1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, lat, e, nrd, nwr, ca, wrw);
        n_cmp++;
        if ({lat, nrd, nwr, wrw} !== {32'd2, 32'd0, 32'd1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL sw: lat=%0d rd=%0d wr=%0d word=%h expected 2/0/1/deadbeef", lat, nrd, nwr, wrw);
        end
        run_req(1'b0, 3'b000, 32'h1007, 32'h0, lat, e, nrd, nwr, ca, wrw);
        n_cmp++;
        if (rdata !== 32'hFFFFFFDE) begin
            n_fail++; $display("FAIL lb_lane3: got %h expected ffffffde", rdata);
        end
    endtask

    task automatic test_miss;
        int lat, nrd, nwr, extra; logic e; logic [31:0] ca, wrw;
        hit_lat = 9;
        run_req(1'b0, 3'b010, 32'h2000, 32'h0, lat, e, nrd, nwr, ca, wrw);
        n_cmp++;
        if ({lat, e, nrd, rdata} !== {32'd11, 1'b0, 32'd10, 32'h01234567}) begin
            n_fail++; $display("FAIL miss_lw: lat=%0d err=%b rd=%0d rdata=%h expected 11/0/10/01234567", lat, e, nrd, rdata);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++; $display("FAIL miss_single_done: %0d extra done pulses, expected 0", extra);
        end
        hit_lat = 0;
    endtask

    task automatic test_errors;
        logic [31:0] ads [4] = '{32'h1001, 32'h1002, 32'h1000, 32'h1000};
        logic [2:0]  f3s [4] = '{3'b001, 3'b010, 3'b011, 3'b110};
        logic        wes [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat, nrd, nwr; logic e; logic [31:0] ca, wrw, prev;
        prev = rdata;
        for (int i = 0; i < 4; i++) begin
            run_req(wes[i], f3s[i], ads[i], 32'h0, lat, e, nrd, nwr, ca, wrw);
            n_cmp++;
            if ({lat, e, nrd, nwr} !== {32'd1, 1'b1, 32'd0, 32'd0}) begin
                n_fail++; $display("FAIL err%0d: lat=%0d err=%b rd=%0d wr=%0d expected 1/1/0/0", i, lat, e, nrd, nwr);
            end
            n_cmp++;
            if (rdata !== prev) begin
                n_fail++; $display("FAIL err%0d_rdata: got %h expected %h", i, rdata, prev);
            end
        end
    endtask

    task automatic run_wd(input logic hit_at_expiry, input logic exp_err);
        int lat, nwr; logic e; logic [31:0] wrw;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h3000; req_wdata = 32'h55AA33CC;
        wd_hit = 1'b0; wd_req_valid = 1'b1;
        @(posedge clk);
        #1 wd_req_valid = 1'b0;
        lat = -1; e = 1'bx; nwr = 0; wrw = 32'hx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (wd_c_write) begin
                nwr++; wrw = {wd_c_data_in[3], wd_c_data_in[2], wd_c_data_in[1], wd_c_data_in[0]};
            end
            if (wd_done) begin lat = n; e = wd_err; break; end
            if (n == 8 && hit_at_expiry) wd_hit = 1'b1;
        end
        wd_hit = 1'b0;
        n_cmp++;
        if ({lat, e, nwr, wd_c_write} !== {32'd9, exp_err, 32'd8, 1'b0}) begin
            n_fail++; $display("FAIL wd%0d: lat=%0d err=%b wr=%0d c_write=%b expected 9/%b/8/0", hit_at_expiry, lat, e, nwr, wd_c_write, exp_err);
        end
        n_cmp++;
        if ({wrw, wd_c_addr, wd_rdata} !== {32'h55AA33CC, 32'h3000, 32'h0}) begin
            n_fail++; $display("FAIL wd%0d_data: word=%h addr=%h rdata=%h expected 55aa33cc/3000/0", hit_at_expiry, wrw, wd_c_addr, wd_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({wd_ready, wd_done} !== 2'b10) begin
            n_fail++; $display("FAIL wd%0d_ready: ready=%b done=%b expected 1/0", hit_at_expiry, wd_ready, wd_done);
        end
    endtask

    task automatic test_watchdog;
        run_wd(1'b0, 1'b1);
        run_wd(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        int lat, nrd, nwr, dn; logic e; logic [31:0] ca, wrw;
        hit_lat = 9;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2000; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (c_read !== 1'b1) begin
            n_fail++; $display("FAIL mid_in_read: c_read=%b expected 1", c_read);
        end
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if ({ready, done, err, c_read, c_write, rdata, c_addr} !== {5'b10000, 64'h0}) begin
            n_fail++; $display("FAIL mid_reset: ctrl=%b rdata=%h c_addr=%h expected 10000/0/0", {ready, done, err, c_read, c_write}, rdata, c_addr);
        end
        dn = 0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        n_cmp++;
        if (dn !== 0) begin
            n_fail++; $display("FAIL mid_no_done: %0d done pulses, expected 0", dn);
        end
        hit_lat = 0;
        run_req(1'b0, 3'b010, 32'h1000, 32'h0, lat, e, nrd, nwr, ca, wrw);
        n_cmp++;
        if ({lat, e, rdata} !== {32'd2, 1'b0, 32'h7799CAFE}) begin
            n_fail++; $display("FAIL mid_after: lat=%0d err=%b rdata=%h expected 2/0/7799cafe", lat, e, rdata);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; both_cnt = 0; miss_cnt = 0; hit_lat = 0;
        req_valid = 1'b0; wd_req_valid = 1'b0; wd_hit = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        pre_we = 1'b0; pre_idx = 4'h0; pre_val = 32'h0;
        test_reset;
        preload(4'd4, 32'h8899AABB);
        preload(4'd8, 32'h01234567);
        test_loads;
        test_stores;
        test_miss;
        test_errors;
        test_watchdog;
        test_reset_mid;
        n_cmp++;
        if (both_cnt !== 0) begin
            n_fail++; $display("FAIL strobe_exclusive: %0d cycles with c_read and c_write both high, expected 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
